// File: rtl/ap_perf_pkg.sv
// Shared types and constants for the ap_ctrl performance monitor.
package ap_perf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_BUSY      = 2'd1,
        ST_DONE_WAIT = 2'd2
    } ap_state_e;

    localparam logic [2:0] SEL_STARTS  = 3'd0;
    localparam logic [2:0] SEL_DONES   = 3'd1;
    localparam logic [2:0] SEL_BUSY    = 3'd2;
    localparam logic [2:0] SEL_STALL   = 3'd3;
    localparam logic [2:0] SEL_LAT_LST = 3'd4;
    localparam logic [2:0] SEL_LAT_MAX = 3'd5;
    localparam logic [2:0] SEL_LAT_MIN = 3'd6;
    localparam logic [2:0] SEL_STATE   = 3'd7;

    localparam int DEF_CNT_W = 32;
    localparam int DEF_LAT_W = 24;

endpackage

// File: rtl/ap_perf_channel.sv
// One ap_ctrl handshake tracker: transaction FSM plus saturating statistics.
//
// state        | meaning
// ST_IDLE      | no transaction in flight, waiting for ap_start
// ST_BUSY      | started, latency counter running until ap_done
// ST_DONE_WAIT | done seen, downstream holding ap_continue low (stall)
module ap_perf_channel
    import ap_perf_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int LAT_W = DEF_LAT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             ready,
    input  logic             done,
    input  logic             cont,
    input  logic             hold,
    input  logic             clear,
    output ap_state_e        state,
    output logic [CNT_W-1:0] starts,
    output logic [CNT_W-1:0] dones,
    output logic [CNT_W-1:0] busy,
    output logic [CNT_W-1:0] stall,
    output logic [LAT_W-1:0] lat_last,
    output logic [LAT_W-1:0] lat_max,
    output logic [LAT_W-1:0] lat_min
);

    logic [LAT_W-1:0] lat;
    logic [LAT_W-1:0] lat_inc;
    logic [LAT_W-1:0] meas;
    logic             launch;
    logic             complete;

    always_comb begin
        lat_inc  = (lat == '1) ? lat : lat + LAT_W'(1);
        launch   = (state == ST_IDLE) && start;
        // a same-cycle start/done measures as a one-cycle transaction
        meas     = (state == ST_IDLE) ? LAT_W'(1) : lat_inc;
        complete = done && ((state == ST_BUSY) || launch);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            lat      <= '0;
            starts   <= '0;
            dones    <= '0;
            busy     <= '0;
            stall    <= '0;
            lat_last <= '0;
            lat_max  <= '0;
            lat_min  <= '1;
        end else if (clear) begin
            state    <= ST_IDLE;
            lat      <= '0;
            starts   <= '0;
            dones    <= '0;
            busy     <= '0;
            stall    <= '0;
            lat_last <= '0;
            lat_max  <= '0;
            lat_min  <= '1;
        end else if (!hold) begin
            if (start && ready && starts != '1)
                starts <= starts + CNT_W'(1);
            if ((launch || state == ST_BUSY) && busy != '1)
                busy <= busy + CNT_W'(1);
            if (state == ST_DONE_WAIT && !cont && stall != '1)
                stall <= stall + CNT_W'(1);
            if (complete) begin
                if (dones != '1)
                    dones <= dones + CNT_W'(1);
                lat_last <= meas;
                if (meas > lat_max)
                    lat_max <= meas;
                if (meas < lat_min)
                    lat_min <= meas;
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        lat   <= LAT_W'(1);
                        state <= done ? (cont ? ST_IDLE : ST_DONE_WAIT) : ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    lat <= lat_inc;
                    if (done)
                        state <= cont ? ST_IDLE : ST_DONE_WAIT;
                end
                ST_DONE_WAIT: begin
                    if (cont)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/ap_ctrl_perf_monitor.sv
// Multi-channel ap_ctrl performance monitor: per-channel trackers, a global
// freeze flag, and a one-cycle registered statistics readout port.
module ap_ctrl_perf_monitor
    import ap_perf_pkg::*;
#(
    parameter int N_CH  = 8,
    parameter int CNT_W = DEF_CNT_W,
    parameter int LAT_W = DEF_LAT_W,
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_CH-1:0]  ap_start,
    input  logic [N_CH-1:0]  ap_ready,
    input  logic [N_CH-1:0]  ap_done,
    input  logic [N_CH-1:0]  ap_continue,
    input  logic             finish,
    input  logic             clear,
    input  logic             rd_en,
    input  logic [CH_W-1:0]  rd_ch,
    input  logic [2:0]       rd_sel,
    output logic             rd_valid,
    output logic [CNT_W-1:0] rd_data,
    output logic             frozen
);

    ap_state_e        c_state  [N_CH];
    logic [CNT_W-1:0] c_starts [N_CH];
    logic [CNT_W-1:0] c_dones  [N_CH];
    logic [CNT_W-1:0] c_busy   [N_CH];
    logic [CNT_W-1:0] c_stall  [N_CH];
    logic [LAT_W-1:0] c_last   [N_CH];
    logic [LAT_W-1:0] c_max    [N_CH];
    logic [LAT_W-1:0] c_min    [N_CH];
    logic [CNT_W-1:0] rd_mux;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        ap_perf_channel #(
            .CNT_W (CNT_W),
            .LAT_W (LAT_W)
        ) u_ch (
            .clock    (clock),
            .reset    (reset),
            .start    (ap_start[i]),
            .ready    (ap_ready[i]),
            .done     (ap_done[i]),
            .cont     (ap_continue[i]),
            .hold     (frozen),
            .clear    (clear),
            .state    (c_state[i]),
            .starts   (c_starts[i]),
            .dones    (c_dones[i]),
            .busy     (c_busy[i]),
            .stall    (c_stall[i]),
            .lat_last (c_last[i]),
            .lat_max  (c_max[i]),
            .lat_min  (c_min[i])
        );
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            frozen <= 1'b0;
        else if (clear)
            frozen <= 1'b0;
        else if (finish)
            frozen <= 1'b1;
    end

    // Latency fields are resized to the counter width (zero-extend or truncate).
    always_comb begin
        rd_mux = '0;
        if (int'(rd_ch) < N_CH) begin
            case (rd_sel)
                SEL_STARTS:  rd_mux = c_starts[rd_ch];
                SEL_DONES:   rd_mux = c_dones[rd_ch];
                SEL_BUSY:    rd_mux = c_busy[rd_ch];
                SEL_STALL:   rd_mux = c_stall[rd_ch];
                SEL_LAT_LST: rd_mux = CNT_W'(c_last[rd_ch]);
                SEL_LAT_MAX: rd_mux = CNT_W'(c_max[rd_ch]);
                SEL_LAT_MIN: rd_mux = CNT_W'(c_min[rd_ch]);
                SEL_STATE:   rd_mux = CNT_W'(c_state[rd_ch]);
                default:     rd_mux = '0;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en)
                rd_data <= rd_mux;
        end
    end

endmodule

// File: tb/tb_ap_ctrl_perf_monitor.sv
// Directed bench: a 6-channel monitor plus a 2-channel 4-bit monitor for saturation.
module tb_ap_ctrl_perf_monitor;
    import ap_perf_pkg::*;

    localparam int N = 6;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] ap_start = '0;
    logic [N-1:0] ap_ready = '1;
    logic [N-1:0] ap_done = '0;
    logic [N-1:0] ap_continue = '1;
    logic         finish = 1'b0;
    logic         clear = 1'b0;
    logic         rd_en = 1'b0;
    logic [2:0]   rd_ch = '0;
    logic [2:0]   rd_sel = '0;
    logic         rd_valid, frozen;
    logic [31:0]  rd_data;
    logic         rd_valid_s, frozen_s;
    logic [3:0]   rd_data_s;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int          ch;
        int          sel;
        logic [31:0] exp;
        bit          sat;
        string       name;
    } vec_t;

    vec_t tbl[$];

    ap_ctrl_perf_monitor #(.N_CH(N), .CNT_W(32), .LAT_W(24)) dut (
        .clock       (clock),
        .reset       (reset),
        .ap_start    (ap_start),
        .ap_ready    (ap_ready),
        .ap_done     (ap_done),
        .ap_continue (ap_continue),
        .finish      (finish),
        .clear       (clear),
        .rd_en       (rd_en),
        .rd_ch       (rd_ch),
        .rd_sel      (rd_sel),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .frozen      (frozen)
    );

    ap_ctrl_perf_monitor #(.N_CH(2), .CNT_W(4), .LAT_W(4)) dut_s (
        .clock       (clock),
        .reset       (reset),
        .ap_start    (ap_start[1:0]),
        .ap_ready    (ap_ready[1:0]),
        .ap_done     (ap_done[1:0]),
        .ap_continue (ap_continue[1:0]),
        .finish      (finish),
        .clear       (clear),
        .rd_en       (rd_en),
        .rd_ch       (rd_ch[0:0]),
        .rd_sel      (rd_sel),
        .rd_valid    (rd_valid_s),
        .rd_data     (rd_data_s),
        .frozen      (frozen_s)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic read(input int ch, input int sel, input logic [31:0] exp,
                        input bit sat, input string name);
        rd_en  = 1'b1;
        rd_ch  = 3'(ch);
        rd_sel = 3'(sel);
        tick();
        rd_en = 1'b0;
        if (sat) begin
            check({name, " valid"}, {31'd0, rd_valid_s}, 32'd1);
            check(name, {28'd0, rd_data_s}, exp);
        end else begin
            check({name, " valid"}, {31'd0, rd_valid}, 32'd1);
            check(name, rd_data, exp);
        end
    endtask

    task automatic txn(input int ch);
        ap_start[ch] = 1'b1;
        tick();
        ap_start[ch] = 1'b0;
        ap_done[ch]  = 1'b1;
        tick();
        ap_done[ch]  = 1'b0;
    endtask

    initial begin
        // reset behaviour, with a read request pending
        rd_en = 1'b1;
        tick();
        tick();
        check("reset rd_valid", {31'd0, rd_valid}, 32'd0);
        check("reset rd_data", rd_data, 32'd0);
        check("reset frozen", {31'd0, frozen}, 32'd0);
        rd_en = 1'b0;
        #3 reset = 1'b0;
        tick();
        read(0, SEL_LAT_MIN, 32'h00FF_FFFF, 0, "post-reset ch0 min");
        read(2, SEL_STATE, 32'd0, 0, "post-reset ch2 state");

        // ch0: start, 3 busy cycles, done with continue=1 -> latency 5
        ap_start[0] = 1'b1;
        tick();
        ap_start[0] = 1'b0;
        repeat (3) tick();
        ap_done[0] = 1'b1;
        tick();
        ap_done[0] = 1'b0;

        // ch3: done with continue low through 6 wait cycles
        ap_continue[3] = 1'b0;
        ap_start[3] = 1'b1;
        tick();
        ap_start[3] = 1'b0;
        ap_done[3]  = 1'b1;
        tick();
        ap_done[3]  = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i == 2) read(3, SEL_STATE, 32'd2, 0, "ch3 state in wait");
            else tick();
        end
        ap_continue[3] = 1'b1;
        tick();

        // ch1: same-cycle start/done, then a 3-cycle transaction
        ap_start[1] = 1'b1;
        ap_done[1]  = 1'b1;
        tick();
        ap_done[1]  = 1'b0;
        tick();
        ap_start[1] = 1'b0;
        tick();
        ap_done[1] = 1'b1;
        tick();
        ap_done[1] = 1'b0;

        // ch2, ch4, ch5 simultaneous 3-cycle transactions
        ap_start = 6'b110100;
        tick();
        ap_start = '0;
        tick();
        ap_done = 6'b110100;
        tick();
        ap_done = '0;

        tbl.push_back('{0, SEL_STARTS,  32'd1, 0, "ch0 starts"});
        tbl.push_back('{0, SEL_DONES,   32'd1, 0, "ch0 dones"});
        tbl.push_back('{0, SEL_BUSY,    32'd5, 0, "ch0 busy"});
        tbl.push_back('{0, SEL_STALL,   32'd0, 0, "ch0 stall"});
        tbl.push_back('{0, SEL_LAT_LST, 32'd5, 0, "ch0 last"});
        tbl.push_back('{0, SEL_LAT_MAX, 32'd5, 0, "ch0 max"});
        tbl.push_back('{0, SEL_LAT_MIN, 32'd5, 0, "ch0 min"});
        tbl.push_back('{0, SEL_STATE,   32'd0, 0, "ch0 state"});
        tbl.push_back('{3, SEL_STALL,   32'd6, 0, "ch3 stall"});
        tbl.push_back('{3, SEL_STATE,   32'd0, 0, "ch3 state after"});
        tbl.push_back('{3, SEL_BUSY,    32'd2, 0, "ch3 busy"});
        tbl.push_back('{3, SEL_LAT_LST, 32'd2, 0, "ch3 last"});
        tbl.push_back('{1, SEL_STARTS,  32'd2, 0, "ch1 starts"});
        tbl.push_back('{1, SEL_DONES,   32'd2, 0, "ch1 dones"});
        tbl.push_back('{1, SEL_LAT_MIN, 32'd1, 0, "ch1 min"});
        tbl.push_back('{1, SEL_LAT_MAX, 32'd3, 0, "ch1 max"});
        tbl.push_back('{1, SEL_LAT_LST, 32'd3, 0, "ch1 last"});
        tbl.push_back('{2, SEL_DONES,   32'd1, 0, "ch2 dones"});
        tbl.push_back('{4, SEL_LAT_LST, 32'd3, 0, "ch4 last"});
        tbl.push_back('{5, SEL_LAT_MAX, 32'd3, 0, "ch5 max"});
        tbl.push_back('{6, SEL_STARTS,  32'd0, 0, "ch N_CH data"});
        tbl.push_back('{0, SEL_LAT_LST, 32'd5, 1, "sat ch0 last"});
        tbl.push_back('{1, SEL_LAT_MIN, 32'd1, 1, "sat ch1 min"});
        foreach (tbl[i]) read(tbl[i].ch, tbl[i].sel, tbl[i].exp, tbl[i].sat, tbl[i].name);

        // back-to-back reads, first one concurrent with a ch0 start
        rd_en = 1'b1;
        rd_ch = 3'd0;
        rd_sel = SEL_STARTS;
        ap_start[0] = 1'b1;
        tick();
        check("b2b pre-update starts", rd_data, 32'd1);
        ap_start[0] = 1'b0;
        tick();
        check("b2b updated starts", rd_data, 32'd2);
        ap_done[0] = 1'b1;
        rd_ch = 3'd3;
        rd_sel = SEL_STALL;
        tick();
        check("b2b ch3 stall", rd_data, 32'd6);
        ap_done[0] = 1'b0;
        rd_ch = 3'd6;
        rd_sel = SEL_STARTS;
        tick();
        check("b2b ch N_CH valid", {31'd0, rd_valid}, 32'd1);
        check("b2b ch N_CH data", rd_data, 32'd0);
        rd_en = 1'b0;

        // clear, then saturate the 4-bit instance
        clear = 1'b1;
        tick();
        clear = 1'b0;
        read(1, SEL_DONES, 32'd0, 0, "clear ch1 dones");
        read(1, SEL_LAT_MIN, 32'h00FF_FFFF, 0, "clear ch1 min");
        for (int i = 0; i < 20; i++) txn(0);
        read(0, SEL_STARTS, 32'd15, 1, "sat starts");
        read(0, SEL_DONES, 32'd15, 1, "sat dones");
        read(0, SEL_BUSY, 32'd15, 1, "sat busy");
        read(0, SEL_LAT_LST, 32'd2, 1, "sat last");
        read(0, SEL_STARTS, 32'd20, 0, "wide starts 20");

        finish = 1'b1;
        tick();
        finish = 1'b0;
        check("frozen after finish", {31'd0, frozen}, 32'd1);
        check("sat frozen after finish", {31'd0, frozen_s}, 32'd1);
        txn(0);
        txn(0);
        ap_start[0] = 1'b1;
        tick();
        ap_start[0] = 1'b0;
        read(0, SEL_STARTS, 32'd20, 0, "frozen starts");
        read(0, SEL_DONES, 32'd20, 0, "frozen dones");
        read(0, SEL_STATE, 32'd0, 0, "frozen state");
        read(0, SEL_STARTS, 32'd15, 1, "sat frozen starts");
        check("still frozen", {31'd0, frozen}, 32'd1);

        // clear wins over a simultaneous finish
        clear = 1'b1;
        finish = 1'b1;
        tick();
        clear = 1'b0;
        finish = 1'b0;
        check("clear+finish frozen", {31'd0, frozen}, 32'd0);
        read(0, SEL_STARTS, 32'd0, 0, "clear ch0 starts");
        read(0, SEL_LAT_MIN, 32'hF, 1, "sat clear min");

        // reset during BUSY cycle 2, while frozen and with rd_valid high
        ap_start[0] = 1'b1;
        tick();
        ap_start[0] = 1'b0;
        tick();
        rd_en = 1'b1;
        rd_ch = 3'd0;
        rd_sel = SEL_STARTS;
        finish = 1'b1;
        tick();
        finish = 1'b0;
        check("pre-reset frozen", {31'd0, frozen}, 32'd1);
        check("pre-reset data", rd_data, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("async reset frozen", {31'd0, frozen}, 32'd0);
        check("async reset rd_valid", {31'd0, rd_valid}, 32'd0);
        check("async reset rd_data", rd_data, 32'd0);
        rd_en = 1'b0;
        tick();
        tick();
        #3 reset = 1'b0;
        tick();
        read(0, SEL_STARTS, 32'd0, 0, "mid reset starts");
        read(0, SEL_BUSY, 32'd0, 0, "mid reset busy");
        read(0, SEL_STATE, 32'd0, 0, "mid reset state");
        read(0, SEL_LAT_MIN, 32'h00FF_FFFF, 0, "mid reset min");
        ap_start[0] = 1'b1;
        ap_done[0]  = 1'b1;
        tick();
        ap_start[0] = 1'b0;
        ap_done[0]  = 1'b0;
        read(0, SEL_DONES, 32'd1, 0, "resume dones");
        read(0, SEL_LAT_LST, 32'd1, 0, "resume last");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
